// File: rtl/mem_io_responder.sv
// Memory-side endpoint of the CPU byte bus: RAM plus the I/O window at 0x30000 (UART TX FIFO, RX source, cycle counter, stop flag).
// Optional build macro MEMIO_RX_EN enables the UART receive path; without it RX reads return 0x00.
module mem_io_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TXQ_LOG2      = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int                   TXQ_DEPTH    = 1 << TXQ_LOG2;
    localparam logic [TXQ_LOG2:0]    TXQ_DEPTH_C  = (TXQ_LOG2+1)'(TXQ_DEPTH);
    localparam logic [TXQ_LOG2-1:0]  PTR_ONE      = TXQ_LOG2'(1'b1);
    localparam logic [TXQ_LOG2:0]    CNT_ONE      = (TXQ_LOG2+1)'(1'b1);
    localparam logic [17:0]          IO_TX_ADDR   = 18'h30000;
    localparam logic [17:0]          IO_STOP_ADDR = 18'h30004;
    localparam logic [17:0]          IO_SNAP1     = 18'h30005;
    localparam logic [17:0]          IO_SNAP2     = 18'h30006;
    localparam logic [17:0]          IO_SNAP3     = 18'h30007;

    logic [7:0]               ram_r [0:(1<<RAM_ADDR_BITS)-1];
    logic [7:0]               txq_r [0:TXQ_DEPTH-1];
    logic [7:0]               ram_rd_r;
    logic [7:0]               io_rd_r;
    logic                     sel_ram_r;
    logic [31:0]              counter_r;
    logic [31:0]              snap_r;
    logic [TXQ_LOG2-1:0]      head_r;
    logic [TXQ_LOG2-1:0]      tail_r;
    logic [TXQ_LOG2:0]        count_r;
    logic                     program_stop_r;
    logic                     tx_overflow_r;

    logic [17:0]              addr_s;
    logic                     io_sel_s;
    logic [RAM_ADDR_BITS-1:0] ram_idx_s;
    logic                     ram_we_s;
    logic                     io_wr_s;
    logic                     io_rd_s;
    logic                     enq_req_s;
    logic                     enq_s;
    logic                     deq_s;
    logic                     fifo_full_s;
    logic [7:0]               enq_data_s;
    logic [TXQ_LOG2:0]        free_s;
    logic                     rx_pop_s;
    logic [7:0]               rx_byte_s;
    logic [7:0]               io_data_s;
    logic                     mem_a_unused_s;

    assign addr_s         = mem_a[17:0];
    assign mem_a_unused_s = ^mem_a[31:18];
    assign io_sel_s       = (addr_s[17:16] == 2'b11);
    assign ram_idx_s      = mem_a[RAM_ADDR_BITS-1:0];
    assign ram_we_s       = mem_wr & ~io_sel_s;
    assign io_wr_s        = mem_wr & io_sel_s & ~program_stop_r;
    assign io_rd_s        = ~mem_wr & io_sel_s;

    // The stop write enqueues a 0x00 terminator that bypasses the zero filter.
    assign enq_req_s   = io_wr_s & (((addr_s == IO_TX_ADDR) & (mem_dout != 8'h00)) | (addr_s == IO_STOP_ADDR));
    assign enq_data_s  = (addr_s == IO_STOP_ADDR) ? 8'h00 : mem_dout;
    assign fifo_full_s = (count_r == TXQ_DEPTH_C);
    assign enq_s       = enq_req_s & ~fifo_full_s;
    assign deq_s       = tx_valid & tx_ready;
    assign free_s      = TXQ_DEPTH_C - count_r;

    assign io_buffer_full = (int'(free_s) <= FULL_MARGIN);
    assign tx_valid       = (count_r != {(TXQ_LOG2+1){1'b0}});
    assign tx_data        = tx_valid ? txq_r[head_r] : 8'h00;
    assign program_stop   = program_stop_r;
    assign tx_overflow    = tx_overflow_r;
    assign mem_din        = sel_ram_r ? ram_rd_r : io_rd_r;

`ifdef MEMIO_RX_EN
    assign rx_pop_s  = io_rd_s & (addr_s == IO_TX_ADDR) & rx_valid & ~rst_in;
    assign rx_byte_s = rx_data;
`else
    logic rx_unused_s;
    assign rx_unused_s = ^{rx_valid, rx_data};
    assign rx_pop_s    = 1'b0;
    assign rx_byte_s   = 8'h00;
`endif
    assign rx_ready = rx_pop_s;

    // I/O read data selection for the current request
    always_comb begin
        io_data_s = 8'h00;
        case (addr_s)
            IO_TX_ADDR:   io_data_s = rx_pop_s ? rx_byte_s : 8'h00;
            IO_STOP_ADDR: io_data_s = counter_r[7:0];
            IO_SNAP1:     io_data_s = snap_r[15:8];
            IO_SNAP2:     io_data_s = snap_r[23:16];
            IO_SNAP3:     io_data_s = snap_r[31:24];
            default:      io_data_s = 8'h00;
        endcase
    end

    // RAM array: write at the edge, registered read (old data on same-edge write)
    always_ff @(posedge clk_in) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= mem_dout;
        end
        ram_rd_r <= ram_r[ram_idx_s];
    end

    // Read-return path, cycle counter and snapshot
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_ram_r <= 1'b0;
            io_rd_r   <= 8'h00;
            counter_r <= 32'h0000_0000;
            snap_r    <= 32'h0000_0000;
        end else begin
            sel_ram_r <= ~mem_wr & ~io_sel_s;
            io_rd_r   <= io_rd_s ? io_data_s : 8'h00;
            counter_r <= counter_r + 32'd1;
            if (io_rd_s && (addr_s == IO_STOP_ADDR)) begin
                snap_r <= counter_r;
            end
        end
    end

    // TX FIFO storage; contents are don't-care while count is zero
    always_ff @(posedge clk_in) begin
        if (enq_s) begin
            txq_r[tail_r] <= enq_data_s;
        end
    end

    // TX FIFO pointers/count and sticky status flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r         <= {TXQ_LOG2{1'b0}};
            tail_r         <= {TXQ_LOG2{1'b0}};
            count_r        <= {(TXQ_LOG2+1){1'b0}};
            program_stop_r <= 1'b0;
            tx_overflow_r  <= 1'b0;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (deq_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (enq_req_s && fifo_full_s) begin
                tx_overflow_r <= 1'b1;
            end
            if (io_wr_s && (addr_s == IO_STOP_ADDR)) begin
                program_stop_r <= 1'b1;
            end
        end
    end

endmodule
